inst_fetch_unit: RTL and testbench
==================================

// Module: inst_fetch_unit
// PURPOSE
//  Initiator side of the instruction ROM interface: owns the fetch PC and drives rom_addr.
//  Samples rom_data/rom_accessable in the same cycle, since the ROM is combinational.
//  Buffers fetched words in a small prefetch queue with valid/ready toward the decode stage.
//  Supports PC redirect (jump/branch/exception) with queue flush.
//  Converts ROM "not accessable" into a tagged fault entry instead of silently returning zero.
// PARAMETERS
//  RESET_PC  32'h00000000  fetch address loaded on reset (ROM boot vector)
//  DEPTH     4             prefetch queue entries; power of two, >= 2
// PORTS
//  clk             in   1   clock, all state updates on rising edge
//  reset           in   1   synchronous, active-high
//  rom_addr        out  32  fetch address to ROM = pc register (no combinational path from inputs)
//  rom_data        in   32  ROM instruction word for rom_addr, valid same cycle
//  rom_accessable  in   1   1 = rom_data valid; 0 = unmapped/misaligned address
//  redirect_valid  in   1   load redirect_pc into fetch PC and flush queue
//  redirect_pc     in   32  new fetch address
//  out_valid       out  1   queue head valid
//  out_inst        out  32  head instruction (32'h00000000 when out_fault)
//  out_pc          out  32  address the head instruction was fetched from
//  out_fault       out  1   head entry came from an inaccessible address
//  out_ready       in   1   consumer accepts head when out_valid & out_ready
// BEHAVIOUR
//  Reset: pc=RESET_PC, queue empty (count=0), stopped=0; out_valid=0, out_fault=0,
//   out_inst=0, out_pc=0; rom_addr=RESET_PC the cycle after reset is sampled.
//  push = ~reset & ~redirect_valid & ~stopped & (count < DEPTH)  (count sampled at cycle start).
//   A pop in the same cycle does not free a slot for that cycle's push (no full bypass).
//  On push: enqueue {pc, rom_accessable ? rom_data : 0, ~rom_accessable}.
//   If rom_accessable=1: pc <= pc + 4 (32-bit wrap, 32'hFFFFFFFC -> 0).
//   If rom_accessable=0: pc unchanged, stopped <= 1; no further pushes until redirect.
//  pop = out_valid & out_ready; head advances next cycle; count updated by push/pop.
//  Simultaneous push and pop: count unchanged, both take effect.
//  Redirect (highest priority after reset): pc <= redirect_pc, queue flushed (count=0),
//   stopped <= 0, no push, and a same-cycle pop is discarded (flush wins).
//   First fetch from redirect_pc is pushed the following cycle, so out_valid rises 2 cycles
//   after redirect_valid is sampled.
//  Latency: fetch->out_valid is 1 cycle (entry visible the cycle after push).
//  Throughput: 1 instruction/cycle while out_ready=1 and addresses are accessable.
//  Misaligned redirect_pc (bits[1:0]!=0): ROM returns accessable=0 -> fault entry, fetch stops.
//  Reset mid-stream: all entries and stopped discarded regardless of redirect/pop.
//  out_* come straight from queue head storage; out_inst/out_pc/out_fault are don't-care
//   when out_valid=0 but must not be X after reset.
// STRUCTURE
//  Shared package ifu_pkg: INST_WIDTH=32, ADDR_WIDTH=32, PC_STEP=4, INST_ZERO,
//   and a fetch_entry packing {pc[31:0], inst[31:0], fault} = 65 bits.
//  Sub-module fetch_queue: synchronous FIFO, DEPTH x 65 bits, with push, pop, flush
//   (flush dominates push/pop) and count/full/empty.
//  Top level holds the pc register, stopped flag and push/redirect control.
// TESTING
//  Reset, out_ready=1: consecutive outputs pc 0x0/0x4/0x8, inst 3c110400/26310000/02200008.
//   Next entry is pc 0xC with out_fault=1 and inst 0; rom_addr then holds at 0xC.
//  out_ready=0 for 10 cycles after reset: count saturates at 4 and rom_addr holds at 0x10.
//   After raising out_ready, pcs 0x0..0xC drain in order with no duplicates or gaps.
//  Redirect to 32'h00400000 while queue holds 3 entries: out_valid=0 the next cycle.
//   First output is pc 0x00400000; old entries are never seen.
//  After fault at 0xC, redirect 32'h00000004: stopped clears and outputs resume at pc 0x4.
//  redirect_pc=32'h00400002 -> single entry pc 0x00400002 with out_fault=1, then no pushes.
//  Redirect and pop in the same cycle, and reset asserted mid-stream with redirect_valid=1:
//   queue is empty, pc=RESET_PC and out_valid=0 the next cycle.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch queue.
package ifu_pkg;

  localparam int INST_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  // Fetch advances one 32-bit word at a time.
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = 32'd4;
  localparam logic [INST_WIDTH-1:0] INST_ZERO = '0;

  // One prefetch queue slot: fetch address, instruction word, and fault tag.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
    logic                  fault;
  } fetch_entry_t;

  localparam int ENTRY_WIDTH = $bits(fetch_entry_t);

  // Build a queue entry from a combinational ROM response. An inaccessible
  // address never leaks ROM data: the word is forced to zero and tagged.
  function automatic fetch_entry_t make_entry(
    input logic [ADDR_WIDTH-1:0] pc,
    input logic [INST_WIDTH-1:0] data,
    input logic                  accessable
  );
    fetch_entry_t e;
    e.pc    = pc;
    e.inst  = accessable ? data : INST_ZERO;
    e.fault = ~accessable;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of fetch entries. Flush empties the queue and
// overrides any push or pop issued in the same cycle. Head data is read
// straight from storage so the consumer sees registered values.
module fetch_queue
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wdata,
  output fetch_entry_t o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  // Full/empty come from the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  always_comb begin
    w_full    = (r_count == CNT_DEPTH);
    w_empty   = (r_count == '0);
    w_do_push = i_push & ~w_full & ~i_flush;
    w_do_pop  = i_pop & ~w_empty & ~i_flush;
  end

  // Storage write; cleared on reset so head fields are never X.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, drives the combinational ROM,
// and buffers fetched words (or fault tags) for the decode stage.
//
// Handshake: an entry transfers to the consumer on a rising edge where
// out_valid and out_ready are both 1. out_valid never depends on out_ready.
// A redirect in the same cycle cancels that transfer (the flush wins).
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_accessable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault,
  input  logic        out_ready
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_stopped;

  fetch_entry_t w_entry;
  fetch_entry_t w_head;
  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;

  // Push/pop decisions and the entry captured from the ROM this cycle.
  always_comb begin
    w_entry = make_entry(r_pc, rom_data, rom_accessable);
    w_push  = ~reset & ~redirect_valid & ~r_stopped & ~w_full;
    w_pop   = ~w_empty & out_ready;
  end

  // Fetch PC and stop flag: reset, then redirect, then normal advance/stop on push.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_stopped <= 1'b0;
    end else if (redirect_valid) begin
      r_pc      <= redirect_pc;
      r_stopped <= 1'b0;
    end else if (w_push) begin
      if (rom_accessable) begin
        r_pc <= r_pc + PC_STEP;
      end else begin
        r_stopped <= 1'b1;
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_entry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rom_addr  = r_pc;
  assign out_valid = ~w_empty;
  assign out_inst  = w_head.inst;
  assign out_pc    = w_head.pc;
  assign out_fault = w_head.fault;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: behavioural ROM, directed scenarios, and a
// scoreboard fed by the stimulus and drained by an output monitor.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_accessable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        out_ready;

  // Low boot region [0, rom_limit) is mapped; high region [0x00400000, 0x00400008) is mapped.
  logic [31:0] rom_limit;

  logic [64:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  inst_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_accessable (rom_accessable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault),
    .out_ready      (out_ready)
  );

  // ---------------- ROM model ----------------
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h3c11_0400;
      32'h0000_0004: return 32'h2631_0000;
      32'h0000_0008: return 32'h0220_0008;
      default:       return {a[15:0], 16'hBEEF};
    endcase
  endfunction

  function automatic logic rom_ok(input logic [31:0] a, input logic [31:0] limit);
    if (a[1:0] != 2'b00) return 1'b0;
    if (a < limit) return 1'b1;
    if (a >= 32'h0040_0000 && a < 32'h0040_0008) return 1'b1;
    return 1'b0;
  endfunction

  // Unmapped reads return garbage so zeroing of fault entries is observable.
  always_comb begin
    rom_accessable = rom_ok(rom_addr, rom_limit);
    rom_data       = rom_accessable ? rom_word(rom_addr) : 32'hDEAD_DEAD;
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] inst, input logic fault);
    exp_q.push_back({pc, inst, fault});
  endtask

  // Hold reset for one edge, check the reset state, then release reset and any redirect.
  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    tick();
    check("rst_out_valid", 65'(out_valid), 65'(1'b0));
    check("rst_rom_addr",  65'(rom_addr),  65'(RESET_PC));
    check("rst_out_inst",  65'(out_inst),  65'(32'h0));
    check("rst_out_pc",    65'(out_pc),    65'(32'h0));
    check("rst_out_fault", 65'(out_fault), 65'(1'b0));
    reset          = 1'b0;
    redirect_valid = 1'b0;
  endtask

  // One-cycle redirect; queue must be empty and PC loaded right after.
  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    exp_q.delete();
    tick();
    redirect_valid = 1'b0;
    check("redir_out_valid", 65'(out_valid), 65'(1'b0));
    check("redir_rom_addr",  65'(rom_addr),  65'(pc));
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d entries still expected after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  // Transfers are sampled mid-cycle; redirect/reset cycles cancel the transfer.
  always @(negedge clk) begin
    logic [64:0] e;
    if (!reset && !redirect_valid && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got pc=%h inst=%h fault=%b expected none",
                 out_pc, out_inst, out_fault);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_inst, out_fault} !== e) begin
          n_fail++;
          $display("FAIL output_entry: got pc=%h inst=%h fault=%b expected pc=%h inst=%h fault=%b",
                   out_pc, out_inst, out_fault, e[64:33], e[32:1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    rom_limit      = 32'h0000_000C;
    tick();

    // Boot stream ending in a fault at 0xC.
    do_reset();
    expect_entry(32'h0000_0000, 32'h3c11_0400, 1'b0);
    expect_entry(32'h0000_0004, 32'h2631_0000, 1'b0);
    expect_entry(32'h0000_0008, 32'h0220_0008, 1'b0);
    expect_entry(32'h0000_000C, 32'h0000_0000, 1'b1);
    wait_drain(30);
    repeat (3) tick();
    check("fault_pc_hold",   65'(rom_addr),  65'(32'h0000_000C));
    check("fault_no_output", 65'(out_valid), 65'(1'b0));

    // Redirect after the fault resumes fetching.
    do_redirect(32'h0000_0004);
    expect_entry(32'h0000_0004, 32'h2631_0000, 1'b0);
    expect_entry(32'h0000_0008, 32'h0220_0008, 1'b0);
    expect_entry(32'h0000_000C, 32'h0000_0000, 1'b1);
    wait_drain(30);

    // Back-pressure: queue fills to 4 entries and fetch holds at 0x10.
    rom_limit = 32'h0000_0100;
    out_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    check("full_rom_addr",  65'(rom_addr),  65'(32'h0000_0010));
    check("full_out_valid", 65'(out_valid), 65'(1'b1));
    check("full_head_pc",   65'(out_pc),    65'(32'h0000_0000));
    rom_limit = 32'h0000_0010;
    expect_entry(32'h0000_0000, 32'h3c11_0400, 1'b0);
    expect_entry(32'h0000_0004, 32'h2631_0000, 1'b0);
    expect_entry(32'h0000_0008, 32'h0220_0008, 1'b0);
    expect_entry(32'h0000_000C, 32'h000C_BEEF, 1'b0);
    expect_entry(32'h0000_0010, 32'h0000_0000, 1'b1);
    out_ready = 1'b1;
    wait_drain(30);

    // Redirect while three entries are buffered; old entries must vanish.
    rom_limit = 32'h0000_0100;
    out_ready = 1'b0;
    do_reset();
    repeat (3) tick();
    check("three_rom_addr", 65'(rom_addr), 65'(32'h0000_000C));
    do_redirect(32'h0040_0000);
    expect_entry(32'h0040_0000, 32'h0000_BEEF, 1'b0);
    expect_entry(32'h0040_0004, 32'h0004_BEEF, 1'b0);
    expect_entry(32'h0040_0008, 32'h0000_0000, 1'b1);
    out_ready = 1'b1;
    wait_drain(30);

    // Misaligned redirect: single fault entry, then fetch stops.
    do_redirect(32'h0040_0002);
    expect_entry(32'h0040_0002, 32'h0000_0000, 1'b1);
    wait_drain(20);
    repeat (4) tick();
    check("misalign_stop_valid", 65'(out_valid), 65'(1'b0));
    check("misalign_stop_addr",  65'(rom_addr),  65'(32'h0040_0002));

    // Redirect coinciding with a pop: the pop is discarded by the flush.
    out_ready = 1'b0;
    do_reset();
    repeat (2) tick();
    out_ready = 1'b1;
    do_redirect(32'h0040_0000);
    expect_entry(32'h0040_0000, 32'h0000_BEEF, 1'b0);
    expect_entry(32'h0040_0004, 32'h0004_BEEF, 1'b0);
    expect_entry(32'h0040_0008, 32'h0000_0000, 1'b1);
    wait_drain(30);

    // Reset mid-stream with redirect and pop also asserted: reset wins.
    out_ready = 1'b0;
    do_reset();
    repeat (2) tick();
    rom_limit      = 32'h0000_000C;
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0000;
    do_reset();
    expect_entry(32'h0000_0000, 32'h3c11_0400, 1'b0);
    expect_entry(32'h0000_0004, 32'h2631_0000, 1'b0);
    expect_entry(32'h0000_0008, 32'h0220_0008, 1'b0);
    expect_entry(32'h0000_000C, 32'h0000_0000, 1'b1);
    wait_drain(30);
    repeat (3) tick();

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
